case_5_mul_pipe_hs: RTL and testbench
=====================================

// Module: case_5_mul_pipe_hs
// PURPOSE
//  Parametrised pipelined multiplier: successor to the single-cycle combinational multiplier cores.
//  Adds NUM_STAGE register stages and a valid/ready handshake with whole-pipe stall.
//  Adds per-transaction operand signedness and a wrap or saturate narrowing mode with an overflow flag.
//  Sits between HLS datapath stages that need a multiplier retimed across several cycles.
// PARAMETERS
//  ID          1   instance tag, no functional effect
//  NUM_STAGE   2   pipeline depth in cycles, legal range 1..8
//  din0_WIDTH  10  operand A width
//  din1_WIDTH  5   operand B width
//  dout_WIDTH  15  result width, any value >= 2
//  SAT_MODE    0   0 = wrap (truncate), 1 = saturate on narrowing
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           synchronous reset, active-high
//  in_valid   in   1           operand beat valid
//  in_ready   out  1           block accepts a beat this cycle
//  din0       in   din0_WIDTH  operand A
//  din1       in   din1_WIDTH  operand B
//  din0_sgn   in   1           1 = din0 is two's complement, 0 = unsigned
//  din1_sgn   in   1           1 = din1 is two's complement, 0 = unsigned
//  out_valid  out  1           result beat valid
//  out_ready  in   1           consumer accepts the result
//  dout       out  dout_WIDTH  narrowed product
//  ovf        out  1           narrowing lost information on this beat
// BEHAVIOUR
//  Reset
//    - All stage valid bits clear.
//    - out_valid=0, dout=0, ovf=0.
//    - in_ready=1 in the first cycle after reset.
//    - Reset asserted mid-operation discards every in-flight beat; no partial output.
//  Handshake
//    - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
//    - A beat is accepted when in_valid & in_ready.
//    - On stall every stage, including its data and valid bit, holds.
//    - Otherwise all stages advance by one. Bubbles are carried, not collapsed.
//  Latency and throughput
//    - A beat accepted at edge N shows out_valid at edge N+NUM_STAGE when no stall occurs.
//    - Throughput is 1 beat per cycle. Order is preserved.
//    - dout and ovf hold stable while out_valid & ~out_ready.
//  Arithmetic
//    - Operand X is extended to Wx+1 bits with msb = (sgn ? X[Wx-1] : 0).
//    - Product is computed signed, then taken to P = din0_WIDTH + din1_WIDTH bits (exact).
//    - Result type is signed if din0_sgn | din1_sgn, else unsigned. Sign flags travel with the beat.
//  Narrowing
//    - dout_WIDTH >= P: sign- or zero-extend per result type; ovf = 0.
//    - dout_WIDTH < P, SAT_MODE=0: dout = P[dout_WIDTH-1:0].
//      ovf = 1 if the dropped bits are not the sign/zero extension of the kept bits.
//    - dout_WIDTH < P, SAT_MODE=1: on overflow clamp to type max/min and set ovf = 1.
//      Signed limits are 2^(D-1)-1 and -2^(D-1); unsigned max is 2^D-1.
//  Register placement
//    - Multiply after stage 1 register; narrowing in the last stage.
//    - NUM_STAGE=1 puts multiply and narrowing in one stage.
// TESTING
//  1. Defaults, signed x signed: din0=0x200 (-512), din1=0x10 (-16) -> two cycles later out_valid=1, dout=0x2000 (8192), ovf=0.
//  2. Unsigned x unsigned: din0=1023, din1=31 -> dout=0x7BE1 (31713), ovf=0.
//  3. Mixed: din0=0x3FF signed (-1), din1=31 unsigned -> dout=0x7FE1 (-31), ovf=0.
//  4. Stream 8 beats back-to-back, out_ready=0 on cycles 3..5.
//     -> in_ready=0 exactly while out_valid&~out_ready; all 8 results in order; none lost or duplicated.
//  5. dout_WIDTH=8, signed 100 x 20 (=2000):
//     SAT_MODE=1 -> dout=0x7F, ovf=1; SAT_MODE=0 -> dout=0xD0, ovf=1.
//  6. Two beats in flight with NUM_STAGE=4, reset pulsed for 1 cycle.
//     -> out_valid stays 0 for the next 4 cycles; dout=0; next accepted beat returns correctly.

Source files
------------

// File: rtl/case_5_mul_pipe_hs.sv
// case_5_mul_pipe_hs
//   Pipelined multiplier with a valid/ready handshake and whole-pipe stall.
//   Each beat carries its own operand signedness. The exact product is
//   narrowed to dout_WIDTH bits by wrapping or saturating, and ovf flags
//   any lost information.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   operand beat handshake
//   din0, din1            operands A and B
//   din0_sgn, din1_sgn    1 = operand is two's complement, 0 = unsigned
//   out_valid / out_ready result beat handshake
//   dout                  narrowed product
//   ovf                   narrowing lost information on this beat
module case_5_mul_pipe_hs #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 15,
    parameter int SAT_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din0_sgn,
    input  logic                  din1_sgn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH;

    if (NUM_STAGE < 1 || NUM_STAGE > 8 || dout_WIDTH < 2 || ID < 0) begin : g_param_err
        $error("case_5_mul_pipe_hs: illegal parameter set");
    end

    // The product of the (W0+1) x (W1+1) bit extended operands always fits in
    // PW bits for the result type, so PW-bit modular multiplication is exact.
    function automatic logic [PW-1:0] mul_ext(
        input logic [din0_WIDTH-1:0] a,
        input logic [din1_WIDTH-1:0] b,
        input logic                  a_sgn,
        input logic                  b_sgn
    );
        logic signed [din0_WIDTH:0] ax;
        logic signed [din1_WIDTH:0] bx;
        logic signed [PW-1:0]       ae;
        logic signed [PW-1:0]       be;
        ax = {a_sgn & a[din0_WIDTH-1], a};
        bx = {b_sgn & b[din1_WIDTH-1], b};
        ae = PW'(ax);
        be = PW'(bx);
        return ae * be;
    endfunction

    logic stall;
    logic advance;
    logic accept;

    logic [NUM_STAGE-1:0]  valid_q, valid_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;

    // Inputs of the last (narrowing) stage.
    logic [PW-1:0]         nar_prod;
    logic                  nar_sgn;
    logic                  last_in_valid;
    logic [dout_WIDTH-1:0] nar_dout;
    logic                  nar_ovf;

    assign stall     = valid_q[NUM_STAGE-1] & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_q[NUM_STAGE-1];
    assign dout      = dout_q;
    assign ovf       = ovf_q;

    // Valid bits shift together with the data; bubbles are kept.
    always_comb begin
        valid_d = valid_q;
        if (advance) begin
            valid_d[0] = accept;
            for (int s = 1; s < NUM_STAGE; s++) begin
                valid_d[s] = valid_q[s-1];
            end
        end
    end

    if (NUM_STAGE == 1) begin : g_one
        assign nar_prod      = mul_ext(din0, din1, din0_sgn, din1_sgn);
        assign nar_sgn       = din0_sgn | din1_sgn;
        assign last_in_valid = accept;
    end else begin : g_multi
        logic [din0_WIDTH-1:0] a_q, a_d;
        logic [din1_WIDTH-1:0] b_q, b_d;
        logic                  sa_q, sa_d;
        logic                  sb_q, sb_d;
        logic [PW-1:0]         p1;
        logic                  s1;

        always_comb begin
            a_d  = a_q;
            b_d  = b_q;
            sa_d = sa_q;
            sb_d = sb_q;
            if (advance) begin
                a_d  = din0;
                b_d  = din1;
                sa_d = din0_sgn;
                sb_d = din1_sgn;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                a_q  <= '0;
                b_q  <= '0;
                sa_q <= 1'b0;
                sb_q <= 1'b0;
            end else begin
                a_q  <= a_d;
                b_q  <= b_d;
                sa_q <= sa_d;
                sb_q <= sb_d;
            end
        end

        assign p1            = mul_ext(a_q, b_q, sa_q, sb_q);
        assign s1            = sa_q | sb_q;
        assign last_in_valid = valid_q[NUM_STAGE-2];

        if (NUM_STAGE == 2) begin : g_direct
            assign nar_prod = p1;
            assign nar_sgn  = s1;
        end else begin : g_mid
            // Product retiming stages between the multiply and the narrowing.
            logic [PW-1:0]        prod_q [NUM_STAGE-2];
            logic [PW-1:0]        prod_d [NUM_STAGE-2];
            logic [NUM_STAGE-3:0] sgn_q, sgn_d;

            always_comb begin
                prod_d = prod_q;
                sgn_d  = sgn_q;
                if (advance) begin
                    prod_d[0] = p1;
                    sgn_d[0]  = s1;
                    for (int m = 1; m < NUM_STAGE - 2; m++) begin
                        prod_d[m] = prod_q[m-1];
                        sgn_d[m]  = sgn_q[m-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int m = 0; m < NUM_STAGE - 2; m++) begin
                        prod_q[m] <= '0;
                    end
                    sgn_q <= '0;
                end else begin
                    prod_q <= prod_d;
                    sgn_q  <= sgn_d;
                end
            end

            assign nar_prod = prod_q[NUM_STAGE-3];
            assign nar_sgn  = sgn_q[NUM_STAGE-3];
        end
    end

    if (dout_WIDTH >= PW) begin : g_extend
        logic signed [PW:0] ext;
        assign ext      = {nar_sgn & nar_prod[PW-1], nar_prod};
        assign nar_dout = dout_WIDTH'(ext);
        assign nar_ovf  = 1'b0;
    end else begin : g_narrow
        localparam int D = dout_WIDTH;
        // Signed fits when the dropped bits plus the kept msb are all equal;
        // unsigned fits when the dropped bits are all zero.
        logic [PW-D:0]   hi_s;
        logic [PW-D-1:0] hi_u;
        assign hi_s    = nar_prod[PW-1:D-1];
        assign hi_u    = nar_prod[PW-1:D];
        assign nar_ovf = nar_sgn ? ~((&hi_s) | ~(|hi_s)) : (|hi_u);

        always_comb begin
            nar_dout = nar_prod[D-1:0];
            if (SAT_MODE != 0 && nar_ovf) begin
                if (!nar_sgn) begin
                    nar_dout = '1;
                end else if (nar_prod[PW-1]) begin
                    nar_dout = {1'b1, {(D-1){1'b0}}};
                end else begin
                    nar_dout = {1'b0, {(D-1){1'b1}}};
                end
            end
        end
    end

    // Bubbles reaching the output present dout = 0, ovf = 0.
    always_comb begin
        dout_d = dout_q;
        ovf_d  = ovf_q;
        if (advance) begin
            dout_d = last_in_valid ? nar_dout : '0;
            ovf_d  = last_in_valid & nar_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_case_5_mul_pipe_hs.sv
// Testbench for case_5_mul_pipe_hs: four instances (defaults, 8-bit saturate,
// 8-bit wrap, four-stage) share the input side; each test checks the
// instance its scenario targets.
module tb_case_5_mul_pipe_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [9:0] din0;
    logic [4:0] din1;
    logic       din0_sgn;
    logic       din1_sgn;

    logic        def_in_ready, def_out_valid, def_ovf;
    logic [14:0] def_dout;
    logic        sat_in_ready, sat_out_valid, sat_ovf;
    logic [7:0]  sat_dout;
    logic        wrp_in_ready, wrp_out_valid, wrp_ovf;
    logic [7:0]  wrp_dout;
    logic        ns4_in_ready, ns4_out_valid, ns4_ovf;
    logic [14:0] ns4_dout;

    int checks = 0;
    int errors = 0;

    case_5_mul_pipe_hs u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(def_in_ready),
        .din0(din0), .din1(din1), .din0_sgn(din0_sgn), .din1_sgn(din1_sgn),
        .out_valid(def_out_valid), .out_ready(out_ready), .dout(def_dout), .ovf(def_ovf)
    );

    case_5_mul_pipe_hs #(.dout_WIDTH(8), .SAT_MODE(1)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
        .din0(din0), .din1(din1), .din0_sgn(din0_sgn), .din1_sgn(din1_sgn),
        .out_valid(sat_out_valid), .out_ready(out_ready), .dout(sat_dout), .ovf(sat_ovf)
    );

    case_5_mul_pipe_hs #(.dout_WIDTH(8), .SAT_MODE(0)) u_wrp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(wrp_in_ready),
        .din0(din0), .din1(din1), .din0_sgn(din0_sgn), .din1_sgn(din1_sgn),
        .out_valid(wrp_out_valid), .out_ready(out_ready), .dout(wrp_dout), .ovf(wrp_ovf)
    );

    case_5_mul_pipe_hs #(.NUM_STAGE(4)) u_ns4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ns4_in_ready),
        .din0(din0), .din1(din1), .din0_sgn(din0_sgn), .din1_sgn(din1_sgn),
        .out_valid(ns4_out_valid), .out_ready(out_ready), .dout(ns4_dout), .ovf(ns4_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for one cycle, then drop in_valid.
    task automatic pulse(input logic [9:0] a, input logic [4:0] b, input logic sa,
                         input logic sb);
        din0     = a;
        din1     = b;
        din0_sgn = sa;
        din1_sgn = sb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din0      = '0;
        din1      = '0;
        din0_sgn  = 1'b0;
        din1_sgn  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        checks++;
        if (def_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", def_out_valid);
        end
        checks++;
        if (def_dout !== 15'h0) begin
            errors++; $display("FAIL reset_dout: got %h want 0000", def_dout);
        end
        checks++;
        if (def_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_ovf: got %b want 0", def_ovf);
        end
        checks++;
        if (def_in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", def_in_ready);
        end
        checks++;
        if (ns4_out_valid !== 1'b0 || ns4_dout !== 15'h0 || ns4_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ns4: got valid=%b dout=%h rdy=%b want 0/0000/1",
                     ns4_out_valid, ns4_dout, ns4_in_ready);
        end
        checks++;
        if (sat_out_valid !== 1'b0 || wrp_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_narrow_valid: got sat=%b wrap=%b want 0/0",
                     sat_out_valid, wrp_out_valid);
        end
    endtask

    // Spec vectors 1..3 on the default instance, including two-cycle latency.
    task automatic test_arith();
        logic [9:0]  a;
        logic [4:0]  b;
        logic        sa, sb;
        logic [14:0] exp_d;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin a = 10'h200; b = 5'h10; sa = 1; sb = 1; exp_d = 15'h2000; end
                1:       begin a = 10'd1023; b = 5'd31; sa = 0; sb = 0; exp_d = 15'h7BE1; end
                default: begin a = 10'h3FF; b = 5'd31; sa = 1; sb = 0; exp_d = 15'h7FE1; end
            endcase
            pulse(a, b, sa, sb);
            checks++;
            if (def_out_valid !== 1'b0) begin
                errors++; $display("FAIL arith%0d_early_valid: got %b want 0", i, def_out_valid);
            end
            step();
            checks++;
            if (def_out_valid !== 1'b1) begin
                errors++; $display("FAIL arith%0d_valid: got %b want 1", i, def_out_valid);
            end
            checks++;
            if (def_dout !== exp_d) begin
                errors++; $display("FAIL arith%0d_dout: got %h want %h", i, def_dout, exp_d);
            end
            checks++;
            if (def_ovf !== 1'b0) begin
                errors++; $display("FAIL arith%0d_ovf: got %b want 0", i, def_ovf);
            end
        end
    endtask

    task automatic stream_vec(input int i, output logic [9:0] a, output logic [4:0] b,
                              output logic [14:0] p);
        case (i)
            0:       begin a = 10'd3;    b = 5'd5;  p = 15'd15;    end
            1:       begin a = 10'd100;  b = 5'd7;  p = 15'd700;   end
            2:       begin a = 10'd1023; b = 5'd1;  p = 15'd1023;  end
            3:       begin a = 10'd512;  b = 5'd2;  p = 15'd1024;  end
            4:       begin a = 10'd0;    b = 5'd31; p = 15'd0;     end
            5:       begin a = 10'd17;   b = 5'd17; p = 15'd289;   end
            6:       begin a = 10'd250;  b = 5'd30; p = 15'd7500;  end
            default: begin a = 10'd1000; b = 5'd31; p = 15'd31000; end
        endcase
    endtask

    // Eight beats back-to-back with out_ready low in cycles 3..5.
    task automatic test_back_to_back();
        int          idx;
        int          got;
        logic [9:0]  a;
        logic [4:0]  b;
        logic [14:0] p;
        logic        exp_rdy;
        repeat (3) step();
        idx      = 0;
        got      = 0;
        din0_sgn = 1'b0;
        din1_sgn = 1'b0;
        for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            exp_rdy   = !(cyc >= 3 && cyc <= 5);
            in_valid  = (idx < 8);
            stream_vec(idx, a, b, p);
            din0 = a;
            din1 = b;
            #1;
            checks++;
            if (def_in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL stream_in_ready_c%0d: got %b want %b", cyc, def_in_ready, exp_rdy);
            end
            if (def_out_valid === 1'b1 && out_ready === 1'b1) begin
                stream_vec(got, a, b, p);
                checks++;
                if (def_dout !== p || def_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_beat%0d: got dout=%h ovf=%b want %h/0",
                             got, def_dout, def_ovf, p);
                end
                got++;
            end
            if (in_valid === 1'b1 && def_in_ready === 1'b1) idx++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 8) begin
            errors++; $display("FAIL stream_count: got %0d results want 8", got);
        end
        checks++;
        if (def_out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_extra_beat: got out_valid=%b want 0", def_out_valid);
        end
    endtask

    // Narrowing to 8 bits, saturating and wrapping instances side by side.
    task automatic test_narrow();
        logic [9:0] a;
        logic [4:0] b;
        logic       sa, sb;
        logic [7:0] exp_sat, exp_wrp;
        logic       exp_ovf;
        repeat (3) step();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin a = 10'd100; b = 5'd20; sa = 1; sb = 0;
                         exp_sat = 8'h7F; exp_wrp = 8'hD0; exp_ovf = 1; end
                1: begin a = 10'h200; b = 5'd31; sa = 1; sb = 0;
                         exp_sat = 8'h80; exp_wrp = 8'h00; exp_ovf = 1; end
                2: begin a = 10'h3FD; b = 5'd5;  sa = 1; sb = 0;
                         exp_sat = 8'hF1; exp_wrp = 8'hF1; exp_ovf = 0; end
                3: begin a = 10'd15;  b = 5'd17; sa = 0; sb = 0;
                         exp_sat = 8'hFF; exp_wrp = 8'hFF; exp_ovf = 0; end
                4: begin a = 10'd16;  b = 5'd16; sa = 0; sb = 0;
                         exp_sat = 8'hFF; exp_wrp = 8'h00; exp_ovf = 1; end
                5: begin a = 10'h3F8; b = 5'd16; sa = 1; sb = 0;
                         exp_sat = 8'h80; exp_wrp = 8'h80; exp_ovf = 0; end
                6: begin a = 10'd127; b = 5'd1;  sa = 1; sb = 0;
                         exp_sat = 8'h7F; exp_wrp = 8'h7F; exp_ovf = 0; end
                default: begin a = 10'd128; b = 5'd1; sa = 1; sb = 0;
                         exp_sat = 8'h7F; exp_wrp = 8'h80; exp_ovf = 1; end
            endcase
            pulse(a, b, sa, sb);
            step();
            checks++;
            if (sat_out_valid !== 1'b1 || wrp_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL narrow%0d_valid: got sat=%b wrap=%b want 1/1",
                         i, sat_out_valid, wrp_out_valid);
            end
            checks++;
            if (sat_dout !== exp_sat || sat_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL narrow%0d_sat: got %h/%b want %h/%b",
                         i, sat_dout, sat_ovf, exp_sat, exp_ovf);
            end
            checks++;
            if (wrp_dout !== exp_wrp || wrp_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL narrow%0d_wrap: got %h/%b want %h/%b",
                         i, wrp_dout, wrp_ovf, exp_wrp, exp_ovf);
            end
        end
    endtask

    // Two beats in flight in the four-stage instance, then a one-cycle reset.
    task automatic test_reset_flush();
        repeat (6) step();
        pulse(10'd5, 5'd6, 1'b0, 1'b0);
        pulse(10'd7, 5'd8, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ns4_out_valid !== 1'b0 || ns4_dout !== 15'h0) begin
                errors++;
                $display("FAIL flush_c%0d: got valid=%b dout=%h want 0/0000",
                         k, ns4_out_valid, ns4_dout);
            end
            step();
        end
        pulse(10'd3, 5'd7, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ns4_out_valid !== 1'b0) begin
                errors++; $display("FAIL ns4_early_c%0d: got %b want 0", k, ns4_out_valid);
            end
            step();
        end
        checks++;
        if (ns4_out_valid !== 1'b1 || ns4_dout !== 15'd21 || ns4_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ns4_after_reset: got valid=%b dout=%h ovf=%b want 1/0015/0",
                     ns4_out_valid, ns4_dout, ns4_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_narrow();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
